load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the execute stage's data-memory port and upstream of the data-memory bus.
- Takes the execute stage's memory request (address, write data, width opcode, write enable) and converts it to a word-aligned, byte-strobed valid/ready bus transaction.
- Stalls the core until the transaction completes.
- Returns load data right-justified in bits [width-1:0]; the execute stage performs sign/zero extension.

Parameters:
XLEN, 32, data/address width; only 32 supported
STRB_W, XLEN/8, byte-strobe width
TIMEOUT_CYCLES, 256, watchdog limit (used only with LSU_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  1  memory op request from execute; held stable while o_stall=1
i_we  in  1  1=store, 0=load
i_op  in  3  width: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
i_addr  in  XLEN  byte address (execute ALU result)
i_wdata  in  XLEN  store data, right-justified
o_stall  out  1  hold pipeline
o_done  out  1  one-cycle completion pulse
o_rdata  out  XLEN  load data shifted to bits [0+]; upper bits zero
o_fault  out  1  pulses with o_done on bus error or timeout
o_misaligned  out  1  pulses with o_done on misaligned address or illegal op; no bus access issued
o_bus_avalid  out  1  address/command valid
i_bus_aready  in  1  bus accepts command
o_bus_addr  out  XLEN  {i_addr[XLEN-1:2],2'b00}
o_bus_we  out  1  write command
o_bus_wstrb  out  STRB_W  byte lanes
o_bus_wdata  out  XLEN  lane-shifted store data
i_bus_rvalid  in  1  response valid (loads and stores)
i_bus_rdata  in  XLEN  load word
i_bus_err  in  1  error, qualified by i_bus_rvalid

Behaviour:
- Reset: state IDLE; all outputs 0, including o_bus_* and o_rdata; watchdog counter cleared.
- States: IDLE, CMD, RESP, DONE.
- IDLE, i_req=1:
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal i_op: go to DONE with o_misaligned set.
  - Otherwise: register addr, we, strb and shifted wdata; go to CMD.
- CMD:
  - o_bus_avalid=1; command outputs stable until i_bus_aready.
  - On handshake go to RESP. avalid never drops before aready.
- RESP:
  - Wait for i_bus_rvalid, then go to DONE.
  - Loads register o_rdata = i_bus_rdata >> (8*addr[1:0]), masked to 8/16/32 bits.
  - o_fault = i_bus_err.
  - rvalid in the same cycle as the aready handshake is ignored; responses are accepted only in RESP.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- o_rdata, o_fault and o_misaligned hold their values until the next DONE entry; o_fault and o_misaligned are asserted only in DONE.
- Stores: lanes and strobes.
  - B: wstrb = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: wstrb = 0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: wstrb = 1111.
  - BU/HU on stores are treated as B/H.
  - Loads drive wstrb = 0 and wdata = 0.
- o_stall = i_req & ~o_done (combinational).
- i_req=0 in IDLE keeps the block idle. A new i_req in the cycle after DONE is accepted normally.
- Minimum latency: request to o_done = 3 cycles (IDLE → CMD → RESP → DONE, with aready and rvalid each arriving in their first possible cycle).
- i_req dropping mid-transaction (illegal by protocol): the transaction still completes.
- Reset mid-transaction: immediate return to IDLE. Any in-flight bus response is the bus's responsibility; a stray rvalid seen in IDLE is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter runs in CMD and RESP and clears on every state change.
  - Reaching TIMEOUT_CYCLES → DONE with o_fault=1 and o_rdata=0; o_bus_avalid drops.
- Not defined: no counter; the FSM waits indefinitely for aready/rvalid.

Test Plan:
- LW addr 0x100, aready and rvalid immediate, rdata 0xDEADBEEF → bus_addr 0x100, o_done 3 cycles after req, o_rdata 0xDEADBEEF, o_stall high until done.
- LB addr 0x103, rdata 0x80AABBCC → o_rdata 0x00000080; LHU addr 0x102 → 0x000080AA.
- SB addr 0x201, wdata 0x12345678 → bus_addr 0x200, wstrb 0010, wdata 0x78787878; SH addr 0x202 → wstrb 1100, wdata 0x56785678.
- LW addr 0x102, and LH addr 0x101 → o_misaligned pulse with o_done, o_bus_avalid never asserts.
- aready delayed 4 cycles, rvalid with err=1 → command stable throughout, o_fault=1 with o_done; reset asserted while in RESP → next cycle IDLE, all outputs 0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, rvalid never arrives → o_done and o_fault 8 cycles after entering RESP; without the macro → stall persists.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Turns execute-stage memory requests into word-aligned,
//               byte-strobed valid/ready bus transactions and stalls the core
//               until each completes. Optional watchdog: LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int STRB_W         = XLEN / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_op,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_fault,
    output logic              o_misaligned,
    output logic              o_bus_avalid,
    input  logic              i_bus_aready,
    output logic [XLEN-1:0]   o_bus_addr,
    output logic              o_bus_we,
    output logic [STRB_W-1:0] o_bus_wstrb,
    output logic [XLEN-1:0]   o_bus_wdata,
    input  logic              i_bus_rvalid,
    input  logic [XLEN-1:0]   i_bus_rdata,
    input  logic              i_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN-1:0]    r_rdata;
    logic [STRB_W-1:0]  r_strb;
    logic               r_we;
    logic               r_fault;
    logic               r_misaligned;
    logic [1:0]         r_size;
    logic [1:0]         r_off;

    logic               w_illegal;
    logic               w_misal;
    logic [STRB_W-1:0]  w_strb;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_ld_shift;
    logic [XLEN-1:0]    w_ld_data;
    logic               w_timeout;
    logic               w_done;

    // Request decode: alignment, lane strobes and replicated store data
    always_comb begin
        w_illegal = 1'b0;
        w_misal   = 1'b0;
        w_strb    = '0;
        w_wdata   = '0;
        case (i_op)
            3'b000, 3'b100: begin
                w_strb  = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                w_misal = i_addr[0];
                w_strb  = 4'b0011 << i_addr[1:0];
                w_wdata = {2{i_wdata[15:0]}};
            end
            3'b010: begin
                w_misal = |i_addr[1:0];
                w_strb  = 4'b1111;
                w_wdata = i_wdata;
            end
            default: w_illegal = 1'b1;
        endcase
        if (!i_we) begin
            w_strb  = '0;
            w_wdata = '0;
        end
    end

    assign w_ld_shift = i_bus_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_ld_data = {{(XLEN-8){1'b0}}, w_ld_shift[7:0]};
            2'b01:   w_ld_data = {{(XLEN-16){1'b0}}, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || (w_next != r_state) ||
            !((r_state == S_CMD) || (r_state == S_RESP))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req) w_next = (w_illegal || w_misal) ? S_DONE : S_CMD;
            S_CMD: begin
                // A handshake always wins over a same-cycle timeout
                if (i_bus_aready)   w_next = S_RESP;
                else if (w_timeout) w_next = S_DONE;
            end
            S_RESP:  if (i_bus_rvalid || w_timeout) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_strb       <= '0;
            r_we         <= 1'b0;
            r_fault      <= 1'b0;
            r_misaligned <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && i_req) begin
                if (w_illegal || w_misal) begin
                    r_misaligned <= 1'b1;
                    r_fault      <= 1'b0;
                    r_rdata      <= '0;
                end else begin
                    r_addr  <= {i_addr[XLEN-1:2], 2'b00};
                    r_we    <= i_we;
                    r_strb  <= w_strb;
                    r_wdata <= w_wdata;
                    r_size  <= i_op[1:0];
                    r_off   <= i_addr[1:0];
                end
            end
            if ((r_state == S_RESP) && i_bus_rvalid) begin
                r_fault      <= i_bus_err;
                r_misaligned <= 1'b0;
                r_rdata      <= r_we ? '0 : w_ld_data;
            end else if ((w_next == S_DONE) &&
                         ((r_state == S_CMD) || (r_state == S_RESP))) begin
                r_fault      <= 1'b1;
                r_misaligned <= 1'b0;
                r_rdata      <= '0;
            end
        end
    end

    assign w_done       = (r_state == S_DONE);
    assign o_done       = w_done;
    assign o_stall      = i_req & ~w_done;
    assign o_rdata      = r_rdata;
    assign o_fault      = r_fault & w_done;
    assign o_misaligned = r_misaligned & w_done;
    assign o_bus_avalid = (r_state == S_CMD);
    assign o_bus_addr   = r_addr;
    assign o_bus_we     = r_we;
    assign o_bus_wstrb  = r_strb;
    assign o_bus_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed and randomized bench for load_store_unit with a
//               byte-lane reference model of loads and stores.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        stall, done, fault, misaligned;
    logic [31:0] rdata;
    logic        avalid, aready;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic        rvalid, berr;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_op         (op),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_fault      (fault),
        .o_misaligned (misaligned),
        .o_bus_avalid (avalid),
        .i_bus_aready (aready),
        .o_bus_addr   (bus_addr),
        .o_bus_we     (bus_we),
        .o_bus_wstrb  (bus_wstrb),
        .o_bus_wdata  (bus_wdata),
        .i_bus_rvalid (rvalid),
        .i_bus_rdata  (bus_rdata),
        .i_bus_err    (berr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-lane view of an access of 'size' bytes at offset 'off'
    function automatic void model(input logic m_we, input logic [2:0] m_op,
                                  input logic [31:0] m_addr, input logic [31:0] m_wdata,
                                  input logic [31:0] m_brdata, input logic m_berr,
                                  output logic mis, output logic [3:0] strb,
                                  output logic [31:0] wd, output logic [31:0] rd,
                                  output logic flt);
        int size;
        int off;
        off = int'(m_addr[1:0]);
        case (m_op)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        mis  = (size == 0) || ((off % size) != 0);
        strb = '0;
        wd   = '0;
        rd   = '0;
        flt  = 1'b0;
        if (!mis) begin
            flt = m_berr;
            if (m_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= off && i < off + size) strb[i] = 1'b1;
                    wd[8*i +: 8] = m_wdata[8*(i % size) +: 8];
                end
            end else begin
                for (int j = 0; j < size; j++)
                    rd[8*j +: 8] = m_brdata[8*(off + j) +: 8];
            end
        end
    endfunction

    task automatic run_txn(input logic t_we, input logic [2:0] t_op,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [31:0] t_brdata, input logic t_berr,
                           input int adly, input int rdly);
        logic        e_mis, e_flt;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd;
        model(t_we, t_op, t_addr, t_wdata, t_brdata, t_berr, e_mis, e_strb, e_wd, e_rd, e_flt);
        @(negedge clk);
        req = 1'b1; we = t_we; op = t_op; addr = t_addr; wdata = t_wdata;
        aready = 1'b0; rvalid = 1'b0;
        #1;
        chk("req_stall", {31'd0, stall}, 32'd1);
        chk("req_avalid", {31'd0, avalid}, 32'd0);
        if (!e_mis) begin
            for (int k = 0; k <= adly; k++) begin
                @(negedge clk);
                aready    = (k == adly);
                rvalid    = 1'($urandom_range(0, 1));
                berr      = 1'b1;
                bus_rdata = $urandom;
                #1;
                chk("cmd_avalid", {31'd0, avalid}, 32'd1);
                chk("cmd_addr", bus_addr, {t_addr[31:2], 2'b00});
                chk("cmd_we", {31'd0, bus_we}, {31'd0, t_we});
                chk("cmd_wstrb", {28'd0, bus_wstrb}, {28'd0, e_strb});
                chk("cmd_wdata", bus_wdata, e_wd);
                chk("cmd_done", {31'd0, done}, 32'd0);
            end
            for (int k = 0; k <= rdly; k++) begin
                @(negedge clk);
                aready    = 1'b0;
                rvalid    = (k == rdly);
                berr      = (k == rdly) ? t_berr : 1'b1;
                bus_rdata = (k == rdly) ? t_brdata : $urandom;
                #1;
                chk("resp_avalid", {31'd0, avalid}, 32'd0);
                chk("resp_stall", {31'd0, stall}, 32'd1);
            end
        end
        @(negedge clk);
        rvalid = 1'b0; aready = 1'b0;
        #1;
        chk("done", {31'd0, done}, 32'd1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_avalid", {31'd0, avalid}, 32'd0);
        chk("done_misaligned", {31'd0, misaligned}, {31'd0, e_mis});
        chk("done_fault", {31'd0, fault}, {31'd0, e_flt});
        chk("done_rdata", rdata, e_rd);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; op = 3'd0; addr = '0; wdata = '0;
        aready = 1'b0; rvalid = 1'b0; berr = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_avalid", {31'd0, avalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0);
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1'b0, 0, 0);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 1'b0, 0, 0);
        run_txn(1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 1'b0, 0, 0);
        run_txn(1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 1'b0, 0, 0);
        run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b0, 0, 0);
        run_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b0, 0, 0);
        run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 0, 0);
        run_txn(1'b1, 3'b010, 32'h40C, 32'hCAFEF00D, 32'h0, 1'b1, 4, 1);

        // Reset while in RESP, then a stray rvalid in IDLE
        @(negedge clk);
        req = 1'b1; we = 1'b1; op = 3'b010; addr = 32'h300; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        aready = 1'b1;
        @(negedge clk);
        aready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 1'b0; rvalid = 1'b1; berr = 1'b1;
        #1;
        chk("mid_rst_avalid", {31'd0, avalid}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_bus_addr", bus_addr, 32'd0);
        chk("mid_rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("mid_rst_wdata", bus_wdata, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rvalid = 1'b0; berr = 1'b0;
        #1;
        chk("stray_rvalid_done", {31'd0, done}, 32'd0);
        chk("stray_rvalid_fault", {31'd0, fault}, 32'd0);

        // Missing response: stall holds while the bus stays silent
        @(negedge clk);
        req = 1'b1; we = 1'b0; op = 3'b010; addr = 32'h104;
        @(negedge clk);
        aready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            aready = 1'b0;
        end
        #1;
        chk("hang_stall", {31'd0, stall}, 32'd1);
        chk("hang_done", {31'd0, done}, 32'd0);
        chk("hang_avalid", {31'd0, avalid}, 32'd0);
        @(negedge clk);
        rvalid = 1'b1; berr = 1'b0; bus_rdata = 32'h13572468;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("hang_release_done", {31'd0, done}, 32'd1);
        chk("hang_release_rdata", rdata, 32'h13572468);

        // Randomized traffic, some of it back-to-back
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                    $urandom, $urandom, ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                req = 1'b0;
            end
        end

        @(negedge clk);
        req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
